// File: rtl/tdm_demux_if.sv
// Bus between a 1-bit TDM link receiver and its 16-bit parallel frame output.
// The master modport drives the serial stream. The slave modport is the demux side.
interface tdm_demux_if #(
    parameter int N  = 16,
    parameter int SW = 4
);
    logic          din;
    logic          din_valid;
    logic          sof;
    logic [N-1:0]  out;
    logic          out_valid;
    logic [SW-1:0] slot;
    logic          frame_err;

    modport master (
        output din, din_valid, sof,
        input  out, out_valid, slot, frame_err
    );

    modport slave (
        input  din, din_valid, sof,
        output out, out_valid, slot, frame_err
    );
endinterface

// File: rtl/tdm_demux_1x16.sv
// 1:16 TDM demultiplexer. Serial slot k of a frame lands on out[k].
// Completed frames are presented as a registered word with a one-cycle valid pulse.
module tdm_demux_1x16 #(
    parameter int N  = 16,
    parameter int SW = 4
) (
    input logic        clk,
    input logic        rst,
    tdm_demux_if.slave bus
);
    typedef enum logic {
        IDLE    = 1'b0,
        CAPTURE = 1'b1
    } state_t;

    localparam logic [SW-1:0] LAST_SLOT = SW'(N - 1);

    state_t        state_p0, state_d;
    logic [SW-1:0] slot_p0, slot_d;
    logic [N-1:0]  shadow_p0, shadow_d;
    logic [N-1:0]  out_p0, out_d;
    logic          vld_p0, vld_d;
    logic          err_p0, err_d;

    always_comb begin
        state_d  = state_p0;
        slot_d   = slot_p0;
        shadow_d = shadow_p0;
        out_d    = out_p0;
        vld_d    = 1'b0;
        err_d    = 1'b0;

        if (bus.din_valid) begin
            unique case (state_p0)
                IDLE: begin
                    // Bits arriving before a frame start are dropped silently.
                    if (bus.sof) begin
                        shadow_d[0] = bus.din;
                        slot_d      = SW'(1);
                        state_d     = CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (bus.sof) begin
                        // Resynchronise on the new frame; the partial one is lost.
                        err_d       = 1'b1;
                        shadow_d[0] = bus.din;
                        slot_d      = SW'(1);
                    end else if (slot_p0 == LAST_SLOT) begin
                        out_d   = {bus.din, shadow_p0[N-2:0]};
                        vld_d   = 1'b1;
                        slot_d  = '0;
                        state_d = IDLE;
                    end else begin
                        shadow_d[slot_p0] = bus.din;
                        slot_d            = slot_p0 + SW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    slot_d  = '0;
                end
            endcase
        end
    end

    // Stage p0: all state and outputs registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_p0  <= IDLE;
            slot_p0   <= '0;
            shadow_p0 <= '0;
            out_p0    <= '0;
            vld_p0    <= 1'b0;
            err_p0    <= 1'b0;
        end else begin
            state_p0  <= state_d;
            slot_p0   <= slot_d;
            shadow_p0 <= shadow_d;
            out_p0    <= out_d;
            vld_p0    <= vld_d;
            err_p0    <= err_d;
        end
    end

    assign bus.out       = out_p0;
    assign bus.out_valid = vld_p0;
    assign bus.slot      = slot_p0;
    assign bus.frame_err = err_p0;
endmodule

// File: tb/tb_tdm_demux_1x16.sv
// Directed bench for tdm_demux_1x16 with a queue-based scoreboard.
// Stimulus pushes expected frame/error events; a negedge monitor pops and compares them.
module tb_tdm_demux_1x16;
    logic clk = 1'b0;
    logic rst;

    tdm_demux_if #(.N(16), .SW(4)) bus ();

    tdm_demux_1x16 #(.N(16), .SW(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          err;
        logic [15:0] data;
        int          cyc;
    } ev_t;

    ev_t sb[$];
    int  vcyc[$];
    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor: compares every out_valid / frame_err pulse against the scoreboard.
    always @(negedge clk) begin
        if (bus.out_valid === 1'b1 || bus.frame_err === 1'b1) begin
            check("valid_err_exclusive", {31'd0, bus.out_valid & bus.frame_err}, 32'd0);
            if (sb.size() == 0) begin
                check("unexpected_event", {30'd0, bus.out_valid, bus.frame_err}, 32'd0);
            end else begin
                ev_t e;
                e = sb.pop_front();
                check("event_kind", {31'd0, bus.frame_err}, {31'd0, e.err});
                check("event_cycle", cyc, e.cyc);
                if (!e.err) begin
                    check("out_word", {16'd0, bus.out}, {16'd0, e.data});
                    vcyc.push_back(cyc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic drive(input logic v, input logic s, input logic d);
        bus.din_valid = v;
        bus.sof       = s;
        bus.din       = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    // Sends one frame LSB first. Idle gaps (with sof/din toggled high to prove they
    // are ignored) follow each slot flagged in gaps. first_edge returns the edge
    // that sampled slot 0.
    task automatic send_frame(input logic [15:0] w, input logic [15:0] gaps, input int gaplen,
                              input bit expect_err, output int first_edge);
        ev_t e;
        first_edge = cyc + 1;
        for (int k = 0; k < 16; k++) begin
            if (k == 0 && expect_err) begin
                e.err = 1'b1; e.data = 16'h0; e.cyc = cyc + 1;
                sb.push_back(e);
            end
            if (k == 15) begin
                e.err = 1'b0; e.data = w; e.cyc = cyc + 1;
                sb.push_back(e);
            end
            drive(1'b1, k == 0, w[k]);
            if (gaps[k]) begin
                for (int g = 0; g < gaplen; g++) drive(1'b0, 1'b1, 1'b1);
            end
        end
    endtask

    initial begin
        int fe;
        logic [15:0] part;
        bus.din = 1'b0; bus.din_valid = 1'b0; bus.sof = 1'b0;
        rst = 1'b1;
        do_reset();

        check("reset_out", {16'd0, bus.out}, 32'h0);
        check("reset_slot", {28'd0, bus.slot}, 32'd0);
        check("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("reset_frame_err", {31'd0, bus.frame_err}, 32'd0);

        // Single frame, then out must hold once the pulse ends.
        send_frame(16'haaaa, 16'h0, 0, 1'b0, fe);
        check("aaaa_pulse", {31'd0, bus.out_valid}, 32'd1);
        drive(1'b0, 1'b0, 1'b0);
        check("aaaa_pulse_end", {31'd0, bus.out_valid}, 32'd0);
        check("aaaa_hold", {16'd0, bus.out}, 32'h0000aaaa);

        // Back-to-back frames, no dead cycle.
        vcyc.delete();
        send_frame(16'h5555, 16'h0, 0, 1'b0, fe);
        check("slot_after_frame", {28'd0, bus.slot}, 32'd0);
        send_frame(16'h1234, 16'h0, 0, 1'b0, fe);
        drive(1'b0, 1'b0, 1'b0);
        check("b2b_count", vcyc.size(), 32'd2);
        if (vcyc.size() == 2) check("b2b_spacing", vcyc[1] - vcyc[0], 32'd16);

        // Gapped frame: 16 bits plus 9 idle cycles span 25 cycles.
        vcyc.delete();
        send_frame(16'hf00f, 16'h4081, 3, 1'b0, fe);
        check("gap_slot_reset", {28'd0, bus.slot}, 32'd0);
        drive(1'b0, 1'b0, 1'b0);
        check("gap_count", vcyc.size(), 32'd1);
        if (vcyc.size() == 1) check("gap_span", vcyc[0] - fe + 1, 32'd25);

        // Abort after 5 bits, then a full frame starting with sof.
        part = 16'h001f;
        for (int k = 0; k < 5; k++) drive(1'b1, k == 0, part[k]);
        check("partial_slot", {28'd0, bus.slot}, 32'd5);
        send_frame(16'hc3c3, 16'h0, 0, 1'b1, fe);
        drive(1'b0, 1'b0, 1'b0);
        check("abort_out", {16'd0, bus.out}, 32'h0000c3c3);

        // Stream without sof from IDLE is discarded.
        do_reset();
        for (int i = 0; i < 20; i++) drive(1'b1, 1'b0, i[0]);
        check("nosof_slot", {28'd0, bus.slot}, 32'd0);
        check("nosof_out", {16'd0, bus.out}, 32'h0);

        // Reset mid-frame after slot 9, then a clean frame.
        for (int k = 0; k < 10; k++) drive(1'b1, k == 0, 1'b1);
        check("midframe_slot", {28'd0, bus.slot}, 32'd10);
        do_reset();
        check("rst_mid_out", {16'd0, bus.out}, 32'h0);
        check("rst_mid_slot", {28'd0, bus.slot}, 32'd0);
        check("rst_mid_out_valid", {31'd0, bus.out_valid}, 32'd0);
        send_frame(16'h0001, 16'h0, 0, 1'b0, fe);
        drive(1'b0, 1'b0, 1'b0);
        check("post_rst_out", {16'd0, bus.out}, 32'h00000001);

        drive(1'b0, 1'b0, 1'b0);
        check("scoreboard_drained", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/tdm_demux_1x16.md
# tdm_demux_1x16

Sequential 1:16 time-division demultiplexer; the receive-side counterpart of the 16:1 mux. It accepts a serial bit stream in which each frame is 16 bits, slot 0 first, marked by a start-of-frame strobe. Bit k of a frame is stored to output bit k, so slot k lands where select value k would read it on the mux side. It sits at the far end of a 1-bit TDM link and presents each completed frame as a registered 16-bit word with a one-cycle valid pulse.

## Interface
- N, 16, number of slots per frame (the frame width); fixed at 16 for this block.
- SW, 4, slot index width; log2(N).
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- din  input  1  serial data bit for the current slot.
- din_valid  input  1  din and sof are sampled only when this is high.
- sof  input  1  start of frame; when high with din_valid, din is slot 0.
- out  output  16  last completed frame; out[k] = slot k bit.
- out_valid  output  1  one-cycle pulse when out is updated.
- slot  output  4  index of the next slot to be written (0 while IDLE).
- frame_err  output  1  one-cycle pulse when sof aborts a partial frame.

## Operation
- Two states: IDLE (waiting for sof) and CAPTURE (slots 1..15 outstanding).
- Internal 16-bit shadow register collects bits; out only changes on frame completion.
- IDLE, din_valid=1, sof=1: shadow[0]<=din, slot<=1, go CAPTURE.
- IDLE, din_valid=1, sof=0: bit discarded; no state change, no error.
- CAPTURE, din_valid=1, sof=0, slot<15: shadow[slot]<=din, slot<=slot+1.
- CAPTURE, din_valid=1, sof=0, slot=15: out<={din, shadow[14:0]}, out_valid<=1, slot<=0, go IDLE.
- CAPTURE, din_valid=1, sof=1 (any slot 1..15): frame_err<=1, partial frame discarded, the bit is taken as slot 0 of a new frame (shadow[0]<=din, slot<=1), stay in CAPTURE.
- din_valid=0 in any state: hold everything; out_valid and frame_err are driven low.
- Shadow bits not yet written in the current frame keep stale values. They are never visible, because every slot is rewritten before out loads.
- Slot counter never wraps past 15; the slot=15 write always returns it to 0.
- out_valid and frame_err are mutually exclusive by construction.
- Back-to-back frames: sof on the cycle immediately after the 16th bit is accepted normally, with no dead cycle.

## Timing
- Reset values: out=16'h0000, out_valid=0, frame_err=0, slot=0, state IDLE, shadow=0.
- rst has priority over all inputs. Asserting it mid-frame discards the partial frame and leaves out cleared to 0.
- All outputs are registered; no combinational path from inputs to outputs.
- Latency: out and out_valid update on the same clock edge that samples the 16th bit (slot 15). They are visible in the following cycle.
- Minimum frame time: 16 cycles at din_valid=1 continuously. Maximum throughput is one frame per 16 cycles.
- out_valid and frame_err are high for exactly one cycle per event. out holds its value until the next completed frame.
- slot is valid every cycle and reflects state after the most recent edge.

## Test plan
- Reset, then send 16'haaaa LSB first (sof with slot 0, din_valid=1 for 16 cycles): after the 16th edge, out=16'haaaa and out_valid=1 for one cycle. Then out_valid=0 and out holds aaaa.
- Send 16'h5555, then 16'h1234 back-to-back with no gap: out_valid pulses exactly 16 cycles apart, with out=5555 then 1234.
- Send 16'hf00f with din_valid deasserted for 3 cycles after slots 0, 7 and 14: out=16'hf00f, and out_valid arrives 25 cycles after the first bit.
- Send 5 bits of a frame, then sof=1 with a full 16'hc3c3 frame: frame_err pulses once at the sof edge, no out_valid for the aborted frame, and out=16'hc3c3 after 16 more bits.
- Drive din_valid=1 with sof=0 for 20 cycles from IDLE: slot stays 0, out stays 0, and out_valid and frame_err stay 0.
- Assert rst after slot 9 of a frame, then send 16'h0001: right after reset, out=0, slot=0 and state is IDLE. The next full frame yields out=16'h0001.
